// File: rtl/sdram_stream_reader.sv
// sdram_stream_reader: Avalon-MM read master streaming a contiguous SDRAM region through a prefetch FIFO
module sdram_stream_reader #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 26,
  parameter int LEN_W      = 24,
  parameter int FIFO_DEPTH = 16,
  parameter int MAX_OUT    = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_W-1:0]     cfg_addr,
  input  logic [LEN_W-1:0]      cfg_len,
  input  logic                  cfg_loop,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_W-1:0]     out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_W-1:0]     sdram_addr,
  output logic [DATA_W/8-1:0]   sdram_byteenable_n,
  output logic                  sdram_chipselect,
  output logic [DATA_W-1:0]     sdram_writedata,
  output logic                  sdram_read_n,
  output logic                  sdram_write_n,
  input  logic [DATA_W-1:0]     sdram_readdata,
  input  logic                  sdram_readdata_valid,
  input  logic                  sdram_waitrequest
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int OW = $clog2(MAX_OUT + 1);
  typedef enum logic [1:0] {IDLE, FETCH, FINISH, ABORT} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d, addr_q, addr_d;
  logic [LEN_W-1:0] len_q, len_d, issued_q, issued_d;
  logic loop_q, loop_d, read_n_q, read_n_d, done_q, done_d;
  logic [OW-1:0] outs_q, outs_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
  logic active, accept, hold, push, pop, last;
  logic [CW:0] credit;
  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    addr_d   = addr_q;
    len_d    = len_q;
    issued_d = issued_q;
    loop_d   = loop_q;
    done_d   = 1'b0;
    mem_d    = mem_q;
    active   = state_q == FETCH || state_q == FINISH;
    accept   = !read_n_q && !sdram_waitrequest;
    hold     = !read_n_q && sdram_waitrequest;
    push     = active && sdram_readdata_valid;
    pop      = out_valid && out_ready;
    last     = issued_q + LEN_W'(1) == len_q;
    outs_d   = outs_q + OW'(accept) - OW'(sdram_readdata_valid && state_q != IDLE);
    if (push) mem_d[wr_q] = sdram_readdata;
    wr_d  = wr_q + PW'(push);
    rd_d  = rd_q + PW'(pop);
    cnt_d = cnt_q + CW'(push) - CW'(pop);
    if (state_q == IDLE && start) begin
      state_d  = cfg_len != '0 ? FETCH : IDLE;
      done_d   = cfg_len == '0;
      base_d   = cfg_addr;
      addr_d   = cfg_addr;
      len_d    = cfg_len;
      loop_d   = cfg_loop;
      issued_d = '0;
    end
    if (state_q == FETCH && accept) begin
      addr_d   = last && loop_q ? base_q : addr_q + ADDR_W'(1);
      issued_d = last ? '0 : issued_q + LEN_W'(1);
      state_d  = last && !loop_q ? FINISH : FETCH;
    end
    if (state_q == FINISH && outs_q == '0 && cnt_q == '0) begin
      state_d = IDLE;
      done_d  = 1'b1;
    end
    if (state_q == ABORT && outs_q == '0 && read_n_q) begin
      state_d = IDLE;
      done_d  = 1'b1;
    end
    if (active && abort) begin
      state_d = ABORT;
      cnt_d   = '0;
      wr_d    = '0;
      rd_d    = '0;
    end
    // credit counts FIFO words plus reads in flight so the FIFO can never overflow
    credit   = {1'b0, cnt_d} + (CW+1)'(outs_d);
    read_n_d = hold ? 1'b0 : !(state_d == FETCH && credit < (CW+1)'(FIFO_DEPTH) && outs_d < OW'(MAX_OUT));
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      base_q   <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      issued_q <= '0;
      loop_q   <= 1'b0;
      read_n_q <= 1'b1;
      done_q   <= 1'b0;
      outs_q   <= '0;
      cnt_q    <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      mem_q    <= '{default: '0};
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      issued_q <= issued_d;
      loop_q   <= loop_d;
      read_n_q <= read_n_d;
      done_q   <= done_d;
      outs_q   <= outs_d;
      cnt_q    <= cnt_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      mem_q    <= mem_d;
    end
  end
  assign busy               = state_q != IDLE;
  assign done               = done_q;
  assign out_data           = mem_q[rd_q];
  assign out_valid          = cnt_q != '0;
  assign sdram_addr         = addr_q;
  assign sdram_read_n       = read_n_q;
  assign sdram_chipselect   = ~read_n_q;
  assign sdram_byteenable_n = '0;
  assign sdram_writedata    = '0;
  assign sdram_write_n      = 1'b1;
endmodule

// File: tb/tb_sdram_stream_reader.sv
// tb_sdram_stream_reader: directed and randomized checks of the SDRAM stream reader against a word-sequence model
module tb_sdram_stream_reader;
  localparam int DW = 16;
  localparam int AW = 26;
  localparam int LW = 24;
  localparam int MO = 4;
  logic clock = 1'b0;
  logic reset_n, start, abort, cfg_loop, busy, done, out_valid, out_ready;
  logic [AW-1:0] cfg_addr, sdram_addr;
  logic [LW-1:0] cfg_len;
  logic [DW-1:0] out_data, sdram_writedata, sdram_readdata;
  logic [DW/8-1:0] sdram_byteenable_n;
  logic sdram_chipselect, sdram_read_n, sdram_write_n, sdram_readdata_valid, sdram_waitrequest;
  always #5 clock = ~clock;
  sdram_stream_reader dut (
    .clock(clock), .reset_n(reset_n), .start(start), .abort(abort),
    .cfg_addr(cfg_addr), .cfg_len(cfg_len), .cfg_loop(cfg_loop),
    .busy(busy), .done(done), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .sdram_addr(sdram_addr), .sdram_byteenable_n(sdram_byteenable_n), .sdram_chipselect(sdram_chipselect),
    .sdram_writedata(sdram_writedata), .sdram_read_n(sdram_read_n), .sdram_write_n(sdram_write_n),
    .sdram_readdata(sdram_readdata), .sdram_readdata_valid(sdram_readdata_valid),
    .sdram_waitrequest(sdram_waitrequest)
  );
  typedef struct packed {logic [DW-1:0] data; int due;} rsp_t;
  rsp_t rq[$];
  logic [DW-1:0] exp_q[$];
  logic [AW-1:0] acc_log[$];
  int checks = 0, errors = 0;
  int cyc = 0, accepted = 0, returned = 0, xfer_acc = 0, delivered = 0, done_cnt = 0;
  int lat = 2, stall_left = 0, ready_mode = 1, d_start = 0;
  bit rand_wait = 0, aborting = 0, wreq;
  logic [AW-1:0] m_addr = '0, m_base = '0;
  int m_len = 0, m_issued = 0;
  bit m_loop = 0;
  function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
    return a[15:0] ^ {a[25:16], a[5:0]} ^ 16'h5A3C;
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // slave model, request scoreboard and output scoreboard, all evaluated mid-cycle
  always @(negedge clock) begin
    if (!reset_n) begin
      rq.delete();
      accepted = 0;
      returned = 0;
      sdram_readdata_valid = 1'b0;
      sdram_waitrequest = 1'b0;
    end else begin
      wreq = 1'b0;
      if (stall_left > 0 && xfer_acc == 2 && (stall_left < 5 || !sdram_read_n)) begin
        chk("stall_read_n", sdram_read_n, 0);
        chk("stall_addr", sdram_addr, AW'(m_base + AW'(2)));
        wreq = 1'b1;
        stall_left--;
      end else if (rand_wait) wreq = $urandom_range(0, 3) == 0;
      sdram_waitrequest = wreq;
      out_ready = ready_mode == 2 ? 1'($urandom_range(0, 1)) : ready_mode == 1;
      if (rq.size() > 0 && rq[0].due <= cyc) begin
        sdram_readdata_valid = 1'b1;
        sdram_readdata = rq[0].data;
        void'(rq.pop_front());
        returned++;
      end else begin
        sdram_readdata_valid = 1'b0;
        sdram_readdata = DW'($urandom);
      end
      if (!sdram_read_n && !wreq) begin
        rq.push_back('{data: mem_val(sdram_addr), due: cyc + lat});
        accepted++;
        xfer_acc++;
        acc_log.push_back(sdram_addr);
        chk("outstanding_cap", accepted - returned <= MO, 1);
        if (!aborting) begin
          chk("req_addr", sdram_addr, m_addr);
          chk("req_in_len", m_loop || m_issued < m_len, 1);
          exp_q.push_back(mem_val(m_addr));
          m_addr++;
          m_issued++;
          if (m_loop && m_issued == m_len) begin
            m_addr = m_base;
            m_issued = 0;
          end
        end
      end
      if (out_valid && out_ready) begin
        delivered++;
        if (exp_q.size() == 0) chk("out_expected", out_valid, 0);
        else chk("out_data", out_data, exp_q.pop_front());
      end
      if (done) begin
        done_cnt++;
        chk("busy_at_done", busy, 0);
      end
    end
    cyc++;
  end
  task automatic do_start(input logic [AW-1:0] a, input int len, input bit lp, input bit ab);
    @(negedge clock);
    cfg_addr = a;
    cfg_len = LW'(len);
    cfg_loop = lp;
    start = 1'b1;
    abort = ab;
    m_base = a;
    m_addr = a;
    m_len = len;
    m_issued = 0;
    m_loop = lp;
    exp_q.delete();
    delivered = 0;
    xfer_acc = 0;
    d_start = done_cnt;
    @(negedge clock);
    start = 1'b0;
    abort = 1'b0;
    chk("start_busy", busy, 1);
  endtask
  task automatic finish_xfer(input int len);
    int n = 0;
    while (done_cnt == d_start && n < 2000) begin
      @(negedge clock);
      n++;
    end
    chk("done_seen", done_cnt != d_start, 1);
    repeat (3) @(negedge clock);
    chk("done_once", done_cnt - d_start, 1);
    chk("delivered", delivered, len);
    chk("exp_empty", exp_q.size(), 0);
    chk("idle_read_n", sdram_read_n, 1);
  endtask
  task automatic run_xfer(input logic [AW-1:0] a, input int len);
    do_start(a, len, 1'b0, 1'b0);
    finish_xfer(len);
  endtask
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1);
  end
  initial begin
    int n, d0, a0;
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; cfg_addr = '0; cfg_len = '0; cfg_loop = 1'b0;
    out_ready = 1'b0; sdram_readdata = '0; sdram_readdata_valid = 1'b0; sdram_waitrequest = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_read_n", sdram_read_n, 1);
    chk("rst_cs", sdram_chipselect, 0);
    chk("rst_addr", sdram_addr, 0);
    chk("rst_data", out_data, 0);
    chk("write_n", sdram_write_n, 1);
    chk("byteen_n", sdram_byteenable_n, 0);
    chk("writedata", sdram_writedata, 0);
    reset_n = 1'b1;
    run_xfer(26'h100, 8);
    ready_mode = 0;
    do_start(AW'($urandom), 40, 1'b0, 1'b0);
    repeat (60) @(negedge clock);
    chk("fill_accepts", xfer_acc, 16);
    chk("fill_read_n", sdram_read_n, 1);
    chk("fill_cs", sdram_chipselect, 0);
    chk("fill_valid", out_valid, 1);
    ready_mode = 1;
    finish_xfer(40);
    stall_left = 5;
    run_xfer(26'h3000, 8);
    chk("stall_used", stall_left, 0);
    rand_wait = 1;
    ready_mode = 2;
    acc_log.delete();
    run_xfer(26'h3FFFFFE, 4);
    chk("wrap_count", acc_log.size(), 4);
    chk("wrap_a0", acc_log[0], 26'h3FFFFFE);
    chk("wrap_a1", acc_log[1], 26'h3FFFFFF);
    chk("wrap_a2", acc_log[2], 26'h0);
    chk("wrap_a3", acc_log[3], 26'h1);
    rand_wait = 0;
    ready_mode = 1;
    lat = 3;
    do_start(26'h20, 3, 1'b1, 1'b0);
    n = 0;
    while (delivered < 10 && n < 300) begin
      @(negedge clock);
      n++;
    end
    chk("loop_delivered", delivered >= 10, 1);
    n = 0;
    while (accepted - returned != 3 && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk("three_inflight", accepted - returned, 3);
    abort = 1'b1;
    aborting = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    exp_q.delete();
    d0 = delivered;
    chk("abort_busy", busy, 1);
    chk("abort_flush", out_valid, 0);
    n = 0;
    while (busy && n < 100) begin
      chk("abort_valid_low", out_valid, 0);
      @(negedge clock);
      n++;
    end
    repeat (2) @(negedge clock);
    chk("abort_idle", busy, 0);
    chk("abort_no_out", delivered, d0);
    chk("abort_done_once", done_cnt - d_start, 1);
    aborting = 1'b0;
    lat = 2;
    d0 = done_cnt;
    @(negedge clock);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    repeat (2) @(negedge clock);
    chk("idle_abort_busy", busy, 0);
    chk("idle_abort_no_done", done_cnt, d0);
    do_start(26'h500, 5, 1'b0, 1'b1);
    finish_xfer(5);
    ready_mode = 0;
    do_start(AW'($urandom), 30, 1'b0, 1'b0);
    n = 0;
    while (!(out_valid && !sdram_read_n) && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk("pre_reset_active", out_valid && !sdram_read_n, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_read_n", sdram_read_n, 1);
    chk("async_valid", out_valid, 0);
    chk("async_busy", busy, 0);
    chk("async_cs", sdram_chipselect, 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    ready_mode = 1;
    @(negedge clock);
    d0 = done_cnt;
    a0 = accepted;
    cfg_len = '0;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("len0_done", done, 1);
    chk("len0_busy", busy, 0);
    repeat (3) @(negedge clock);
    chk("len0_once", done_cnt - d0, 1);
    chk("len0_no_req", accepted, a0);
    for (int i = 0; i < 5; i++) begin
      rand_wait = 1;
      ready_mode = 2;
      lat = $urandom_range(1, 4);
      run_xfer(AW'($urandom), $urandom_range(1, 30));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sdram_stream_reader.md
Name: sdram_stream_reader

Overview:
- Single-clock, parametrised Avalon-MM read master.
- Streams a contiguous region of SDRAM words into an internal prefetch FIFO and presents them on a valid/ready output, e.g. as an audio sample source.
- Supports multiple outstanding pipelined reads, loop (wrap-to-start) mode and abort with response draining.
- Sits between the SDRAM controller's Avalon slave port and a consumer in the same clock domain; crossing clock domains is outside this block.

Parameters:
- DATA_W, 16, SDRAM word width and output sample width.
- ADDR_W, 26, SDRAM word address width.
- LEN_W, 24, transfer length counter width, in words.
- FIFO_DEPTH, 16, prefetch FIFO entries; power of two, at least 2.
- MAX_OUT, 4, maximum reads accepted by the slave but not yet returned; range 1..FIFO_DEPTH.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; latches cfg_addr, cfg_len and cfg_loop. Ignored unless IDLE.
- abort  in  1  one-cycle pulse; terminates the current transfer.
- cfg_addr  in  ADDR_W  first word address.
- cfg_len  in  LEN_W  number of words to transfer.
- cfg_loop  in  1  1 = wrap to cfg_addr after cfg_len words and repeat until abort.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when a transfer completes or an abort finishes.
- out_data  out  DATA_W  FIFO head.
- out_valid  out  1  FIFO not empty and not flushing.
- out_ready  in  1  consumer pop; a pop occurs when out_valid && out_ready.
- sdram_addr  out  ADDR_W  read address.
- sdram_byteenable_n  out  DATA_W/8  constant 0.
- sdram_chipselect  out  1  equals ~sdram_read_n.
- sdram_writedata  out  DATA_W  constant 0.
- sdram_read_n  out  1  active-low read request.
- sdram_write_n  out  1  constant 1.
- sdram_readdata  in  DATA_W  returned data.
- sdram_readdata_valid  in  1  returned data valid.
- sdram_waitrequest  in  1  slave stall.

Behaviour:
- Reset (async, reset_n=0) values:
  - state=IDLE; busy, done, out_valid = 0.
  - sdram_read_n = 1; sdram_chipselect = 0; sdram_addr = 0; out_data = 0.
  - FIFO empty; outstanding count = 0; all counters 0.
- States: IDLE, FETCH, FINISH, ABORT.
- IDLE:
  - start with cfg_len != 0 -> FETCH. Latch base=cfg_addr, len=cfg_len, loop=cfg_loop; set addr=base, issued=0.
  - start with cfg_len == 0 -> stay IDLE and pulse done the next cycle.
- FETCH:
  - Request eligibility: issue when (fifo_count + outstanding) < FIFO_DEPTH and outstanding < MAX_OUT. This credit rule guarantees the FIFO never overflows.
  - sdram_read_n=0 with sdram_addr=addr.
  - Once sdram_read_n is low, hold it low with a stable address until accepted: accepted = !sdram_read_n && !sdram_waitrequest.
  - On accept: outstanding++, addr++, issued++.
  - When issued reaches len:
    - loop=1: addr=base, issued=0, stay in FETCH.
    - loop=0: -> FINISH; sdram_read_n returns high the same cycle as the final accept.
  - Address arithmetic is modulo 2^ADDR_W; 0x3FFFFFF+1 wraps to 0.
- FINISH:
  - No requests.
  - When outstanding==0 and FIFO empty -> IDLE, done=1 for 1 cycle.
- Response handling, in FETCH and FINISH:
  - sdram_readdata_valid -> push sdram_readdata into the FIFO and decrement outstanding.
  - Data appears on out_data/out_valid 1 cycle after the push (registered FIFO output).
  - Simultaneous accept and response in one cycle: outstanding is unchanged net.
  - Simultaneous push and pop: fifo_count is unchanged.
- Abort, from FETCH or FINISH (ignored in IDLE and ABORT):
  - Next cycle -> ABORT and flush the FIFO; out_valid=0 from that cycle on.
  - A request stalled by waitrequest in the abort cycle is still held until accepted, then counted outstanding. sdram_read_n goes high the cycle after acceptance.
  - In ABORT, returning data is discarded but decrements outstanding.
  - outstanding==0 and no request pending -> IDLE, done pulse.
- start and abort in the same cycle while IDLE: start wins.
- Ordering: out_data order equals address issue order. The slave returns data in order.

Test Plan:
- addr=0x100, len=8, loop=0, waitrequest=0, 2-cycle read latency, out_ready=1 -> out_data=mem[0x100..0x107] in order; done pulses once; busy falls the same cycle as done.
- FIFO_DEPTH=16, MAX_OUT=4, len=40, out_ready=0 -> exactly 16 reads accepted, then read_n stays high. Outstanding never exceeds 4. Raising out_ready resumes and delivers 40 words with no loss.
- waitrequest held high for 5 cycles on the 3rd request -> sdram_addr stays at base+2 and read_n stays low throughout; no duplicate or skipped address.
- addr=0x3FFFFFE, len=4 -> addresses 0x3FFFFFE, 0x3FFFFFF, 0x0, 0x1.
- loop=1, addr=0x20, len=3, run 10 words -> outputs mem[0x20,0x21,0x22,0x20,...]. Abort with 3 reads in flight -> those 3 responses are discarded, out_valid=0, then done and return to IDLE.
- Mid-FETCH reset_n=0 asynchronously -> read_n=1 and out_valid=0 immediately. start with len=0 -> done pulse only, no SDRAM request.
